// File: rtl/barret_pkg.sv
// Shared constants for the Barrett modular-reduction scheduler (modulus 2671).
// Latency: none (package only).
// Backpressure: none (package only).
package barret_pkg;

   localparam int unsigned Q_DEF     = 2671;
   localparam int unsigned MU_DEF    = 6281;     // floor(2^24 / 2671)
   localparam int unsigned OPW       = 23;       // operand width
   localparam int unsigned RESW      = 12;       // result width
   localparam int unsigned SHIFT     = 12;       // each half of the 2^24 Barrett shift
   localparam int unsigned PRODW     = 36;       // full-width product, never truncated mid-way
   localparam logic [OPW-1:0] RANGE_MAX = 23'd7134240;  // Q*Q-1

   // Operands above Q*Q-1 fall outside the Barrett error bound.
   function automatic logic out_of_range(input logic [OPW-1:0] a);
      return a > RANGE_MAX;
   endfunction

endpackage

// File: rtl/barret_pipe_2671.sv
// Three-stage Barrett reduction datapath with valid/id/err sideband.
// Latency: 3 cycles from in_vld to out_vld; one operand per cycle.
// Backpressure: en=0 freezes every stage, holding all outputs stable.
module barret_pipe_2671
   import barret_pkg::*;
#(
   parameter int unsigned Q   = Q_DEF,
   parameter int unsigned MU  = MU_DEF,
   parameter int unsigned IDW = 2
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            en,
   input  logic            in_vld,
   input  logic [OPW-1:0]  in_dat,
   input  logic [IDW-1:0]  in_id,
   input  logic            in_err,
   output logic            out_vld,
   output logic [RESW-1:0] out_dat,
   output logic [IDW-1:0]  out_id,
   output logic            out_err
);

   localparam int unsigned TW = PRODW - SHIFT;
   localparam logic [PRODW-1:0] QW  = PRODW'(Q);
   localparam logic [PRODW-1:0] MUW = PRODW'(MU);

   logic             s1_vld, s1_err;
   logic [OPW-1:0]   s1_a;
   logic [IDW-1:0]   s1_id;
   logic             s2_vld, s2_err;
   logic [OPW-1:0]   s2_a;
   logic [TW-1:0]    s2_t;
   logic [IDW-1:0]   s2_id;
   logic [PRODW-1:0] mul_hi, mul_q, rem0, rem1, rem2;

   // Quotient estimate and remainder with up to two conditional subtractions.
   always_comb begin
      mul_hi = PRODW'(s1_a >> SHIFT) * MUW;
      mul_q  = PRODW'(s2_t) * QW;
      rem0   = PRODW'(s2_a) - mul_q;   // t never exceeds floor(a/Q), so no underflow
      rem1   = (rem0 >= QW) ? rem0 - QW : rem0;
      rem2   = (rem1 >= QW) ? rem1 - QW : rem1;
   end

   // S1: capture operand, id and range flag.
   always_ff @(posedge clk) begin
      if (rst) begin
         s1_vld <= 1'b0;
         s1_a   <= '0;
         s1_id  <= '0;
         s1_err <= 1'b0;
      end else if (en) begin
         s1_vld <= in_vld;
         s1_a   <= in_dat;
         s1_id  <= in_id;
         s1_err <= in_err;
      end
   end

   // S2: capture the quotient estimate alongside the operand.
   always_ff @(posedge clk) begin
      if (rst) begin
         s2_vld <= 1'b0;
         s2_a   <= '0;
         s2_t   <= '0;
         s2_id  <= '0;
         s2_err <= 1'b0;
      end else if (en) begin
         s2_vld <= s1_vld;
         s2_a   <= s1_a;
         s2_t   <= TW'(mul_hi >> SHIFT);
         s2_id  <= s1_id;
         s2_err <= s1_err;
      end
   end

   // S3: corrected remainder; out-of-range operands keep the low 12 bits.
   always_ff @(posedge clk) begin
      if (rst) begin
         out_vld <= 1'b0;
         out_dat <= '0;
         out_id  <= '0;
         out_err <= 1'b0;
      end else if (en) begin
         out_vld <= s2_vld;
         out_dat <= RESW'(rem2);
         out_id  <= s2_id;
         out_err <= s2_err;
      end
   end

endmodule

// File: rtl/barret_sched_2671.sv
// Round-robin arbiter feeding NREQ requesters into one shared Barrett mod-2671 pipe.
// Latency: 3 cycles from accepting edge to rsp_valid; one grant per cycle.
// Backpressure: rsp_valid & !rsp_ready stalls the pipe and drops every req_ready.
module barret_sched_2671
   import barret_pkg::*;
#(
   parameter int unsigned NREQ = 4,
   parameter int unsigned Q    = Q_DEF,
   parameter int unsigned MU   = MU_DEF,
   localparam int unsigned IDW = (NREQ > 1) ? $clog2(NREQ) : 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [NREQ-1:0]   req_valid,
   input  logic [NREQ*OPW-1:0] req_data,
   output logic [NREQ-1:0]   req_ready,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [RESW-1:0]   rsp_data,
   output logic [IDW-1:0]    rsp_id,
   output logic              rsp_err
);

   logic [IDW-1:0] ptr;
   logic [IDW-1:0] gnt_idx;
   logic [IDW-1:0] cand;
   logic           gnt_any;
   logic           advance;
   logic           accept;
   logic [OPW-1:0] op_dat;
   logic           op_err;

   assign advance = !rsp_valid || rsp_ready;
   assign accept  = gnt_any && advance && !rst;
   assign op_dat  = req_data[32'(gnt_idx)*OPW +: OPW];
   assign op_err  = out_of_range(op_dat);

   // First valid requester at or above the pointer, wrapping modulo NREQ.
   always_comb begin
      gnt_any = 1'b0;
      gnt_idx = '0;
      cand    = '0;
      for (int k = 0; k < int'(NREQ); k++) begin
         cand = IDW'((32'(ptr) + 32'(k)) % NREQ);
         if (!gnt_any && req_valid[cand]) begin
            gnt_any = 1'b1;
            gnt_idx = cand;
         end
      end
   end

   // One-hot ready for the granted requester only while the pipe can move.
   always_comb begin
      req_ready = '0;
      if (accept) req_ready[gnt_idx] = 1'b1;
   end

   // Pointer moves past the winner on acceptance, otherwise holds.
   always_ff @(posedge clk) begin
      if (rst) begin
         ptr <= '0;
      end else if (accept) begin
         if (gnt_idx == IDW'(NREQ - 1)) ptr <= '0;
         else                           ptr <= gnt_idx + IDW'(1);
      end
   end

   barret_pipe_2671 #(
      .Q   (Q),
      .MU  (MU),
      .IDW (IDW)
   ) u_pipe (
      .clk     (clk),
      .rst     (rst),
      .en      (advance),
      .in_vld  (accept),
      .in_dat  (op_dat),
      .in_id   (gnt_idx),
      .in_err  (op_err),
      .out_vld (rsp_valid),
      .out_dat (rsp_data),
      .out_id  (rsp_id),
      .out_err (rsp_err)
   );

endmodule

// File: tb/tb_barret_sched_2671.sv
// Directed self-checking bench for the Barrett mod-2671 scheduler.
// Latency: stimulus and sampling on the falling edge, DUT registers on the rising edge.
// Backpressure: rsp_ready driven directly to exercise stall and release.
module tb_barret_sched_2671;

   localparam int NREQ = 4;
   localparam int Q    = 2671;

   logic          clk = 1'b0;
   logic          rst;
   logic [3:0]    req_valid;
   logic [91:0]   req_data;
   logic [3:0]    req_ready;
   logic          rsp_valid;
   logic          rsp_ready;
   logic [11:0]   rsp_data;
   logic [1:0]    rsp_id;
   logic          rsp_err;

   int n_chk  = 0;
   int n_fail = 0;

   typedef struct {
      logic [22:0] op;
      logic [11:0] exp_dat;
      logic        exp_err;
   } vec_t;

   localparam int NV = 9;
   vec_t vecs [NV];

   barret_sched_2671 #(.NREQ(NREQ)) dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_data  (req_data),
      .req_ready (req_ready),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_data  (rsp_data),
      .rsp_id    (rsp_id),
      .rsp_err   (rsp_err)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic set_req(input int i, input logic [22:0] v);
      req_data[i*23 +: 23] = v;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      int got;
      logic [11:0] exp_q [4];

      vecs[0] = '{23'd5000,    12'd2329, 1'b0};
      vecs[1] = '{23'd0,       12'd0,    1'b0};
      vecs[2] = '{23'd2671,    12'd0,    1'b0};
      vecs[3] = '{23'd123456,  12'd590,  1'b0};
      vecs[4] = '{23'd7134240, 12'd2670, 1'b0};
      vecs[5] = '{23'd8388607, 12'd1667, 1'b1};
      vecs[6] = '{23'd2670,    12'd2670, 1'b0};
      vecs[7] = '{23'd7134241, 12'd0,    1'b1};
      vecs[8] = '{23'd2672,    12'd1,    1'b0};

      // reset state, with a request pending to show ready stays low in reset
      rst       = 1'b1;
      req_valid = 4'b0001;
      req_data  = '0;
      rsp_ready = 1'b1;
      repeat (2) @(negedge clk);
      check("ready in reset", req_ready, 0);
      check("reset valid", rsp_valid, 0);
      check("reset data", rsp_data, 0);
      check("reset id", rsp_id, 0);
      check("reset err", rsp_err, 0);
      req_valid = 4'b0000;
      rst       = 1'b0;
      @(negedge clk);
      check("idle ready", req_ready, 0);

      // back-to-back operands from requester 0, one result per cycle, 3-cycle latency
      for (int i = 0; i < NV + 3; i++) begin
         if (i >= 3) begin
            check($sformatf("tbl%0d valid", i-3), rsp_valid, 1);
            check($sformatf("tbl%0d data", i-3), rsp_data, vecs[i-3].exp_dat);
            check($sformatf("tbl%0d err", i-3), rsp_err, vecs[i-3].exp_err);
            check($sformatf("tbl%0d id", i-3), rsp_id, 0);
         end else begin
            check($sformatf("latency gap %0d", i), rsp_valid, 0);
         end
         if (i < NV) begin
            req_valid = 4'b0001;
            set_req(0, vecs[i].op);
            #1;
            check($sformatf("tbl%0d ready", i), req_ready, 4'b0001);
         end else begin
            req_valid = 4'b0000;
         end
         @(negedge clk);
      end
      check("drain bubble", rsp_valid, 0);

      // round robin across all four requesters
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < NREQ; i++) set_req(i, 23'(3000*i + 7));
      for (int k = 0; k < 11; k++) begin
         if (k >= 3) begin
            check($sformatf("rr%0d valid", k-3), rsp_valid, 1);
            check($sformatf("rr%0d id", k-3), rsp_id, (k-3) % 4);
            check($sformatf("rr%0d data", k-3), rsp_data, (3000*((k-3) % 4) + 7) % Q);
         end else begin
            check($sformatf("rr gap %0d", k), rsp_valid, 0);
         end
         if (k < 8) begin
            req_valid = 4'b1111;
            #1;
            check($sformatf("rr%0d grant", k), req_ready, 4'b0001 << (k % 4));
         end else begin
            req_valid = 4'b0000;
         end
         @(negedge clk);
      end

      // stall with a full pipe, then release and count deliveries
      exp_q[0] = 12'd11;
      exp_q[1] = 12'd19;
      exp_q[2] = 12'd13;
      exp_q[3] = 12'd1986;
      req_valid = 4'b0010;
      set_req(1, 23'd11);
      @(negedge clk);
      set_req(1, 23'd2690);
      @(negedge clk);
      set_req(1, 23'd5355);
      @(negedge clk);
      check("stall head valid", rsp_valid, 1);
      check("stall head data", rsp_data, 11);
      rsp_ready = 1'b0;
      set_req(1, 23'd9999);
      #1;
      check("stall ready", req_ready, 0);
      for (int s = 0; s < 5; s++) begin
         @(negedge clk);
         check($sformatf("stall%0d valid", s), rsp_valid, 1);
         check($sformatf("stall%0d data", s), rsp_data, 11);
         check($sformatf("stall%0d id", s), rsp_id, 1);
         check($sformatf("stall%0d ready", s), req_ready, 0);
      end
      rsp_ready = 1'b1;
      #1;
      check("release ready", req_ready, 4'b0010);
      got = 0;
      for (int c = 0; c < 6; c++) begin
         if (rsp_valid) begin
            if (got < 4) check($sformatf("release%0d data", got), rsp_data, exp_q[got]);
            check($sformatf("release%0d id", got), rsp_id, 1);
            got++;
         end
         if (c == 1) req_valid = 4'b0000;
         @(negedge clk);
      end
      check("release count", got, 4);

      // reset with two operations in flight
      set_req(1, 23'd100);
      set_req(2, 23'd200);
      req_valid = 4'b0110;
      #1;
      check("pre-rst grant a", req_ready, 4'b0100);
      @(negedge clk);
      #1;
      check("pre-rst grant b", req_ready, 4'b0010);
      @(negedge clk);
      rst = 1'b1;
      #1;
      check("ready during rst", req_ready, 0);
      @(negedge clk);
      rst       = 1'b0;
      req_valid = 4'b0000;
      check("post-rst valid", rsp_valid, 0);
      check("post-rst data", rsp_data, 0);
      check("post-rst id", rsp_id, 0);
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         check($sformatf("dropped %0d", c), rsp_valid, 0);
      end
      set_req(3, 23'd300);
      req_valid = 4'b1010;
      #1;
      check("post-rst grant", req_ready, 4'b0010);
      @(negedge clk);
      req_valid = 4'b0000;
      repeat (2) @(negedge clk);
      check("post-rst rsp valid", rsp_valid, 1);
      check("post-rst rsp id", rsp_id, 1);
      check("post-rst rsp data", rsp_data, 100);
      @(negedge clk);
      check("post-rst tail", rsp_valid, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
